// File: rtl/tube_bin2dec.sv
// rtl/tube_bin2dec.sv - binary to six-digit decimal converter feeding the tube scanner
module tube_bin2dec #(
  parameter int           WIDTH     = 20,
  parameter bit           LZ_BLANK  = 1'b1,
  parameter logic [4:0]   DASH_CODE = 5'h10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [4:0]       num5,
  output logic [4:0]       num4,
  output logic [4:0]       num3,
  output logic [4:0]       num2,
  output logic [4:0]       num1,
  output logic [4:0]       num0,
  output logic [5:0]       enb
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [23:0]      bcd;
  logic [23:0]      bcd_adj;
  logic [4:0]       cnt;
  logic             ovf_flag;
  logic [20:0]      bin_ext;
  logic             bin_too_big;
  logic [5:0]       enb_calc;
  logic             lit;

  assign bin_ext     = 21'(bin);
  assign bin_too_big = (bin_ext > 21'd999999);
  assign busy        = (state != IDLE);

  // Overflow detected at acceptance still spends one SHIFT cycle (no shifting) before FINISH.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (ovf_flag || (cnt == 5'(WIDTH - 1))) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 6; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit stays lit once any more-significant digit is non-zero.
  always_comb begin
    lit      = 1'b0;
    enb_calc = 6'b000001;
    for (int i = 5; i >= 1; i--) begin
      lit         = lit | (bcd[4*i +: 4] != 4'd0);
      enb_calc[i] = lit | ~LZ_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      num5     <= 5'h00;
      num4     <= 5'h00;
      num3     <= 5'h00;
      num2     <= 5'h00;
      num1     <= 5'h00;
      num0     <= 5'h00;
      enb      <= 6'b000001;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            bcd      <= '0;
            cnt      <= '0;
            ovf_flag <= bin_too_big;
          end
        end
        SHIFT: begin
          if (!ovf_flag) begin
            {bcd, shreg} <= {bcd_adj, shreg} << 1;
            cnt          <= cnt + 5'd1;
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (ovf_flag) begin
            ovf  <= 1'b1;
            num5 <= DASH_CODE;
            num4 <= DASH_CODE;
            num3 <= DASH_CODE;
            num2 <= DASH_CODE;
            num1 <= DASH_CODE;
            num0 <= DASH_CODE;
            enb  <= 6'b111111;
          end else begin
            ovf  <= 1'b0;
            num5 <= {1'b0, bcd[23:20]};
            num4 <= {1'b0, bcd[19:16]};
            num3 <= {1'b0, bcd[15:12]};
            num2 <= {1'b0, bcd[11:8]};
            num1 <= {1'b0, bcd[7:4]};
            num0 <= {1'b0, bcd[3:0]};
            enb  <= enb_calc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
